// File: rtl/cam_update_pkg.sv
// Shared types, register constants and the exposure payload helper for the
// camera settings RAM batch updater.
package cam_update_pkg;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } reg_write_t;

   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} upd_state_t;

   localparam logic [15:0] REG_EXPOSURE_HI = 16'h3501;
   localparam logic [15:0] REG_EXPOSURE_LO = 16'h3502;
   localparam logic [15:0] REG_AEC_MANUAL  = 16'h3503;

   typedef struct packed {
      logic [47:0] addr;
      logic [23:0] data;
   } exposure_payload_t;

   // Three-slot payload, slot 0 in the LSBs: exposure high nibble, low nibble
   // left-aligned, then the manual-AEC flag.
   function automatic exposure_payload_t pack_exposure(input logic [7:0] exp,
                                                       input logic       manual);
      exposure_payload_t p;
      p.addr = {REG_AEC_MANUAL, REG_EXPOSURE_LO, REG_EXPOSURE_HI};
      p.data = {{7'd0, manual}, {exp[3:0], 4'h0}, {4'h0, exp[7:4]}};
      return p;
   endfunction

endpackage

// File: rtl/cam_slot_scan.sv
// Find-first-set over the pending slot mask; lowest index wins.
module cam_slot_scan #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_reg_update_seq.sv
// Batch writer of camera register slots into the settings RAM window.
// Optional read-back verification is built with CAM_UPDATE_READBACK_EN.
//
// state  | meaning
// IDLE   | port released to init sequencer, ready when init_busy low
// WRITE  | one enabled slot written per cycle
// VERIFY | written slots re-read and compared (read-back builds only)
// DONE   | one-cycle upd_done pulse, port released
module cam_reg_update_seq
   import cam_update_pkg::*;
#(
   parameter int NUM_SLOTS      = 3,
   parameter int RAM_WIDTH      = 24,
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int BASE_ADDR      = 238,
   parameter int IDLE_ADDR      = 255
) (
   input  logic                      clk_camera,
   input  logic                      sys_rst_camera_n,
   input  logic                      upd_valid,
   output logic                      upd_ready,
   input  logic [16*NUM_SLOTS-1:0]   upd_reg_addr,
   input  logic [8*NUM_SLOTS-1:0]    upd_reg_data,
   input  logic [NUM_SLOTS-1:0]      upd_en,
   input  logic                      init_busy,
`ifdef CAM_UPDATE_READBACK_EN
   input  logic [RAM_WIDTH-1:0]      ram_dout,
   output logic                      upd_error,
`endif
   output logic                      ram_sel,
   output logic                      ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_WIDTH-1:0]      ram_din,
   output logic                      upd_done
);

   localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [RAM_ADDR_WIDTH-1:0] IDLE_A = RAM_ADDR_WIDTH'(IDLE_ADDR);

   if (BASE_ADDR + NUM_SLOTS - 1 > (2 ** RAM_ADDR_WIDTH) - 1) begin : g_addr_range_err
      $error("cam_reg_update_seq: slot window exceeds RAM address range");
   end
   if (RAM_WIDTH != 24) begin : g_width_err
      $error("cam_reg_update_seq: RAM_WIDTH must be 24");
   end

   upd_state_t             state;
   logic [NUM_SLOTS-1:0]   pending;
   reg_write_t             snap    [NUM_SLOTS];
   reg_write_t             slot_in [NUM_SLOTS];
   reg_write_t             cur_slot;
   logic [NUM_SLOTS-1:0]   scan_mask;
   logic [NUM_SLOTS-1:0]   scan_clr;
   logic [IW-1:0]          scan_idx;
   logic                   scan_found;
   logic [RAM_ADDR_WIDTH-1:0] slot_addr;
   logic                   ram_sel_q;
   logic                   ram_we_q;

`ifdef CAM_UPDATE_READBACK_EN
   logic [NUM_SLOTS-1:0]   vpending;
   logic                   rd_valid, p1_valid, p2_valid;
   logic [RAM_WIDTH-1:0]   rd_exp, p1_exp, p2_exp;
`endif

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_in[i].addr = upd_reg_addr[16*i +: 16];
         slot_in[i].data = upd_reg_data[8*i +: 8];
      end
   end

   // After the last write, the same scanner walks the read-back mask.
   always_comb begin
      scan_mask = pending;
      if (state == IDLE) scan_mask = upd_en;
`ifdef CAM_UPDATE_READBACK_EN
      else if (state == VERIFY || pending == '0) scan_mask = vpending;
`endif
   end

   cam_slot_scan #(.N(NUM_SLOTS), .IW(IW)) u_scan (
      .mask  (scan_mask),
      .idx   (scan_idx),
      .found (scan_found)
   );

   assign scan_clr  = scan_mask & ~(NUM_SLOTS'(1) << scan_idx);
   assign cur_slot  = (state == IDLE) ? slot_in[scan_idx] : snap[scan_idx];
   assign slot_addr = RAM_ADDR_WIDTH'(BASE_ADDR + int'(scan_idx));

   assign upd_ready = (state == IDLE) && !init_busy;
   // Reset drops the port in the same cycle it is asserted.
   assign ram_sel   = ram_sel_q & sys_rst_camera_n;
   assign ram_we    = ram_we_q & sys_rst_camera_n;

   always_ff @(posedge clk_camera) begin
      if (!sys_rst_camera_n) begin
         state     <= IDLE;
         pending   <= '0;
         snap      <= '{default: '0};
         ram_sel_q <= 1'b0;
         ram_we_q  <= 1'b0;
         ram_addr  <= IDLE_A;
         ram_din   <= '0;
         upd_done  <= 1'b0;
`ifdef CAM_UPDATE_READBACK_EN
         vpending  <= '0;
         rd_valid  <= 1'b0;
         rd_exp    <= '0;
         p1_valid  <= 1'b0;
         p1_exp    <= '0;
         p2_valid  <= 1'b0;
         p2_exp    <= '0;
         upd_error <= 1'b0;
`endif
      end else begin
         ram_sel_q <= 1'b0;
         ram_we_q  <= 1'b0;
         ram_addr  <= IDLE_A;
         ram_din   <= '0;
         upd_done  <= 1'b0;
`ifdef CAM_UPDATE_READBACK_EN
         rd_valid  <= 1'b0;
         p1_valid  <= rd_valid;
         p1_exp    <= rd_exp;
         p2_valid  <= p1_valid;
         p2_exp    <= p1_exp;
         if (p2_valid && ram_dout != p2_exp) upd_error <= 1'b1;
`endif
         case (state)
            IDLE: begin
               if (upd_valid && upd_ready) begin
                  snap <= slot_in;
`ifdef CAM_UPDATE_READBACK_EN
                  vpending <= upd_en;
`endif
                  if (scan_found) begin
                     state     <= WRITE;
                     pending   <= scan_clr;
                     ram_sel_q <= 1'b1;
                     ram_we_q  <= 1'b1;
                     ram_addr  <= slot_addr;
                     ram_din   <= cur_slot;
                  end else begin
                     state    <= DONE;
                     pending  <= '0;
                     upd_done <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (pending != '0) begin
                  pending   <= scan_clr;
                  ram_sel_q <= 1'b1;
                  ram_we_q  <= 1'b1;
                  ram_addr  <= slot_addr;
                  ram_din   <= cur_slot;
               end else begin
`ifdef CAM_UPDATE_READBACK_EN
                  state     <= VERIFY;
                  vpending  <= scan_clr;
                  ram_sel_q <= 1'b1;
                  ram_addr  <= slot_addr;
                  rd_valid  <= 1'b1;
                  rd_exp    <= cur_slot;
`else
                  state    <= DONE;
                  upd_done <= 1'b1;
`endif
               end
            end
`ifdef CAM_UPDATE_READBACK_EN
            VERIFY: begin
               ram_sel_q <= 1'b1;
               if (scan_found) begin
                  vpending <= scan_clr;
                  ram_addr <= slot_addr;
                  rd_valid <= 1'b1;
                  rd_exp   <= cur_slot;
               end else if (!rd_valid && !p1_valid) begin
                  state     <= DONE;
                  ram_sel_q <= 1'b0;
                  upd_done  <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_reg_update_seq.sv
// Self-checking bench for cam_reg_update_seq: per-cycle queue model plus
// directed batches with literal expectations.
module tb_cam_reg_update_seq;
   import cam_update_pkg::*;

   logic        clk_camera = 1'b0;
   logic        sys_rst_camera_n = 1'b0;
   logic        upd_valid = 1'b0;
   logic        init_busy = 1'b0;
   logic [47:0] upd_reg_addr = '0;
   logic [23:0] upd_reg_data = '0;
   logic [2:0]  upd_en = '0;
   logic        upd_ready, ram_sel, ram_we, upd_done;
   logic [7:0]  ram_addr;
   logic [23:0] ram_din;
`ifdef CAM_UPDATE_READBACK_EN
   logic [23:0] ram_dout;
   logic        upd_error;
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   always #5 clk_camera = ~clk_camera;

   cam_reg_update_seq dut (
      .clk_camera       (clk_camera),
      .sys_rst_camera_n (sys_rst_camera_n),
      .upd_valid        (upd_valid),
      .upd_ready        (upd_ready),
      .upd_reg_addr     (upd_reg_addr),
      .upd_reg_data     (upd_reg_data),
      .upd_en           (upd_en),
      .init_busy        (init_busy),
`ifdef CAM_UPDATE_READBACK_EN
      .ram_dout         (ram_dout),
      .upd_error        (upd_error),
`endif
      .ram_sel          (ram_sel),
      .ram_we           (ram_we),
      .ram_addr         (ram_addr),
      .ram_din          (ram_din),
      .upd_done         (upd_done)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: each accepted batch becomes a list of expected output cycles.
   typedef struct {
      bit          sel;
      bit          we;
      int          addr;
      logic [23:0] din;
      bit          done;
   } cyc_t;

   typedef struct {
      int          c;
      int          a;
      logic [23:0] d;
   } wlog_t;

   cyc_t  q[$];
   cyc_t  cur = '{sel: 0, we: 0, addr: 255, din: 24'h0, done: 0};
   wlog_t wl[$];
   int    cyc = 0;
   int    hs_cyc = -1;
   int    hs_cnt = 0;
   int    done_cnt = 0;
   int    done_cyc = -1;

   function automatic cyc_t idle_c();
      cyc_t c;
      c = '{sel: 0, we: 0, addr: 255, din: 24'h0, done: 0};
      return c;
   endfunction

   function automatic bit m_ready();
      return (q.size() == 0) && !cur.sel && !cur.done && !init_busy;
   endfunction

   always @(posedge clk_camera) begin
      bit hs;
      hs = sys_rst_camera_n && upd_valid && m_ready();
      cyc++;
      if (!sys_rst_camera_n) begin
         q.delete();
         cur = idle_c();
      end else begin
         if (hs) begin
            hs_cyc = cyc;
            hs_cnt++;
            for (int i = 0; i < 3; i++)
               if (upd_en[i])
                  q.push_back('{sel: 1, we: 1, addr: 238 + i,
                                din: {upd_reg_addr[16*i +: 16], upd_reg_data[8*i +: 8]}, done: 0});
            if (RB && upd_en != 3'b000) begin
               for (int i = 0; i < 3; i++)
                  if (upd_en[i]) q.push_back('{sel: 1, we: 0, addr: 238 + i, din: 24'h0, done: 0});
               repeat (2) q.push_back('{sel: 1, we: 0, addr: 255, din: 24'h0, done: 0});
            end
            q.push_back('{sel: 0, we: 0, addr: 255, din: 24'h0, done: 1});
         end
         if (q.size() > 0) cur = q.pop_front();
         else cur = idle_c();
      end
   end

   always @(negedge clk_camera) begin
      if (sys_rst_camera_n) begin
         chk("ram_sel", 32'(ram_sel), 32'(cur.sel));
         chk("ram_we", 32'(ram_we), 32'(cur.we));
         chk("ram_addr", 32'(ram_addr), 32'(cur.addr));
         chk("ram_din", 32'(ram_din), 32'(cur.din));
         chk("upd_done", 32'(upd_done), 32'(cur.done));
         chk("upd_ready", 32'(upd_ready), 32'(m_ready()));
         if (ram_we) wl.push_back('{c: cyc, a: int'(ram_addr), d: ram_din});
         if (upd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         chk("ram_we_in_reset", 32'(ram_we), 32'd0);
      end
   end

`ifdef CAM_UPDATE_READBACK_EN
   logic [23:0] mem [256];
   logic [23:0] rd1;
   bit          corrupt = 1'b0;
   always @(posedge clk_camera) begin
      if (ram_sel && ram_we) mem[ram_addr] <= ram_din;
      rd1      <= mem[ram_addr] ^ ((corrupt && ram_addr == 8'd239) ? 24'h000001 : 24'h000000);
      ram_dout <= rd1;
   end
`endif

   task automatic offer(input logic [47:0] a, input logic [23:0] d, input logic [2:0] en);
      int h0;
      h0 = hs_cnt;
      @(negedge clk_camera); #1;
      upd_reg_addr = a;
      upd_reg_data = d;
      upd_en       = en;
      upd_valid    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_camera); #1;
         if (hs_cnt != h0) break;
      end
      upd_valid    = 1'b0;
      upd_reg_addr = '1;
      upd_reg_data = '1;
      upd_en       = '1;
      chk("handshake", 32'(hs_cnt - h0), 32'd1);
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_camera); #1;
         if (done_cnt != d0) break;
      end
      chk("done_seen", 32'(done_cnt - d0), 32'd1);
      @(negedge clk_camera); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exposure_payload_t p;
      int d0;
      int h0;

      repeat (3) @(posedge clk_camera);
      @(negedge clk_camera); #1;
      sys_rst_camera_n = 1'b1;
      @(negedge clk_camera); #1;
      chk("rst_ram_addr", 32'(ram_addr), 32'd255);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_din", 32'(ram_din), 32'd0);
      chk("rst_upd_ready", 32'(upd_ready), 32'd1);
`ifdef CAM_UPDATE_READBACK_EN
      chk("rst_upd_error", 32'(upd_error), 32'd0);
`endif

      // Exposure payload, all slots.
      p = pack_exposure(8'hA5, 1'b1);
      chk("pack_data", 32'(p.data), 32'h0001500A);
      wl.delete(); d0 = done_cnt;
      offer(p.addr, p.data, 3'b111);
      wait_done(d0);
      chk("exp_nwrites", 32'(wl.size()), 32'd3);
      if (wl.size() == 3) begin
         chk("exp_w0_addr", 32'(wl[0].a), 32'd238);
         chk("exp_w0_data", 32'(wl[0].d), 32'h35010A);
         chk("exp_w1_addr", 32'(wl[1].a), 32'd239);
         chk("exp_w1_data", 32'(wl[1].d), 32'h350250);
         chk("exp_w2_addr", 32'(wl[2].a), 32'd240);
         chk("exp_w2_data", 32'(wl[2].d), 32'h350301);
         chk("exp_first_latency", 32'(wl[0].c - hs_cyc), 32'd0);
      end
      chk("exp_done_latency", 32'(done_cyc - hs_cyc), RB ? 32'd8 : 32'd3);

      // Sparse mask; init_busy rising mid-batch must not disturb it.
      wl.delete(); d0 = done_cnt;
      offer({16'h1234, 16'hBEEF, 16'h0042}, {8'h77, 8'h66, 8'h55}, 3'b101);
      init_busy = 1'b1;
      wait_done(d0);
      init_busy = 1'b0;
      chk("sparse_nwrites", 32'(wl.size()), 32'd2);
      if (wl.size() == 2) begin
         chk("sparse_w0_addr", 32'(wl[0].a), 32'd238);
         chk("sparse_w0_data", 32'(wl[0].d), 32'h004255);
         chk("sparse_w1_addr", 32'(wl[1].a), 32'd240);
         chk("sparse_w1_data", 32'(wl[1].d), 32'h123477);
         chk("sparse_consecutive", 32'(wl[1].c - wl[0].c), 32'd1);
      end
      chk("sparse_done_latency", 32'(done_cyc - hs_cyc), RB ? 32'd6 : 32'd2);

      // Empty mask: no RAM access, done one cycle after handshake.
      wl.delete(); d0 = done_cnt;
      offer(48'h0, 24'h0, 3'b000);
      wait_done(d0);
      chk("empty_nwrites", 32'(wl.size()), 32'd0);
      chk("empty_done_latency", 32'(done_cyc - hs_cyc), 32'd0);

      // init_busy holds off the handshake.
      wl.delete(); d0 = done_cnt; h0 = hs_cnt;
      @(negedge clk_camera); #1;
      init_busy    = 1'b1;
      upd_reg_addr = {16'hAAAA, 16'hBBBB, 16'hCCCC};
      upd_reg_data = {8'h11, 8'h22, 8'h33};
      upd_en       = 3'b111;
      upd_valid    = 1'b1;
      repeat (4) @(negedge clk_camera);
      #1;
      chk("busy_ready_low", 32'(upd_ready), 32'd0);
      chk("busy_no_hs", 32'(hs_cnt - h0), 32'd0);
      chk("busy_no_writes", 32'(wl.size()), 32'd0);
      init_busy = 1'b0;
      @(posedge clk_camera); #1;
      chk("busy_release_hs", 32'(hs_cnt - h0), 32'd1);
      upd_valid = 1'b0;
      wait_done(d0);
      chk("busy_nwrites", 32'(wl.size()), 32'd3);

      // Reset during the second write cycle aborts the batch.
      wl.delete(); d0 = done_cnt;
      offer(p.addr, p.data, 3'b111);
      @(posedge clk_camera); #1;
      sys_rst_camera_n = 1'b0;
      #1;
      chk("abort_we_low", 32'(ram_we), 32'd0);
      @(posedge clk_camera); #1;
      sys_rst_camera_n = 1'b1;
      repeat (6) @(negedge clk_camera);
      #1;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_ready", 32'(upd_ready), 32'd1);
      chk("abort_idle_addr", 32'(ram_addr), 32'd255);
      chk("abort_nwrites", 32'(wl.size()), 32'd1);

`ifdef CAM_UPDATE_READBACK_EN
      corrupt = 1'b1;
      d0 = done_cnt;
      offer(p.addr, p.data, 3'b111);
      wait_done(d0);
      chk("rb_error_set", 32'(upd_error), 32'd1);
      corrupt = 1'b0;
      d0 = done_cnt;
      offer(p.addr, p.data, 3'b111);
      wait_done(d0);
      chk("rb_error_sticky", 32'(upd_error), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
